// File: rtl/alu_issue.sv
// Issue/writeback stage for the external 16-bit ALU: owns the 8x16 register file and the zero flag.
// Optional operand forwarding from WB is enabled by defining ALU_ISSUE_FWD_EN; otherwise hazards stall one cycle.
module alu_issue #(
  parameter int NREGS = 8,
  parameter int IMM_W = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [1:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  output logic        res_valid,
  output logic [2:0]  res_rd,
  output logic [15:0] res_data,
  output logic        zero_flag
);

  logic        iss_valid;
  logic [15:0] iss_instr;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        wb_zero;
  logic [15:0] regs [NREGS];

  logic [2:0]  rs1, rs2;
  logic        imm_sel;
  logic [15:0] imm_ext;
  logic [15:0] rf_a, rf_b;
  logic [15:0] op_a, op_b;
  logic        hit_a, hit_b;
  logic        stall;
  logic        advance;

  assign rs1     = iss_instr[10:8];
  assign imm_sel = iss_instr[7];
  assign rs2     = iss_instr[6:4];
  assign imm_ext = {{(16-IMM_W){1'b0}}, iss_instr[IMM_W-1:0]};

  // r0 is hardwired to zero on the read side; its storage is never written
  assign rf_a = (rs1 == 3'd0) ? 16'h0000 : regs[rs1];
  assign rf_b = (rs2 == 3'd0) ? 16'h0000 : regs[rs2];

  assign hit_a = wb_valid && (wb_rd != 3'd0) && (rs1 == wb_rd);
  assign hit_b = wb_valid && (wb_rd != 3'd0) && !imm_sel && (rs2 == wb_rd);

`ifdef ALU_ISSUE_FWD_EN
  assign stall = 1'b0;
  assign op_a  = hit_a ? wb_data : rf_a;
  assign op_b  = imm_sel ? imm_ext : (hit_b ? wb_data : rf_b);
`else
  // Hold IS one cycle so the retiring write lands in the register file first
  assign stall = iss_valid && (hit_a || hit_b);
  assign op_a  = rf_a;
  assign op_b  = imm_sel ? imm_ext : rf_b;
`endif

  assign in_ready = !stall;
  assign advance  = iss_valid && !stall;

  assign alu_a  = iss_valid ? op_a : 16'h0000;
  assign alu_b  = iss_valid ? op_b : 16'h0000;
  assign alu_op = iss_valid ? iss_instr[15:14] : 2'b00;

  assign res_valid = wb_valid;
  assign res_rd    = wb_rd;
  assign res_data  = wb_data;

  // IS stage: control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      wb_valid  <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      if (in_ready) iss_valid <= in_valid;
      wb_valid <= advance;
      if (wb_valid) zero_flag <= wb_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) iss_instr <= in_instr;
  end

  // WB stage: result capture, cleared on reset because it drives res_*
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_rd   <= 3'd0;
      wb_data <= 16'h0000;
      wb_zero <= 1'b0;
    end else if (advance) begin
      wb_rd   <= iss_instr[13:11];
      wb_data <= alu_result;
      wb_zero <= alu_zero;
    end
  end

  // Retire: register file write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= 16'h0000;
    end else if (wb_valid && (wb_rd != 3'd0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU attached to the alu_* ports.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] alu_a, alu_b;
  logic [1:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_zero;
  logic        res_valid;
  logic [2:0]  res_rd;
  logic [15:0] res_data;
  logic        zero_flag;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .res_valid  (res_valid),
    .res_rd     (res_rd),
    .res_data   (res_data),
    .zero_flag  (zero_flag)
  );

  always #5 clk = ~clk;

  // External ALU
  always_comb begin
    alu_result = 16'h0000;
    case (alu_op)
      2'b00: alu_result = alu_a + alu_b;
      2'b01: alu_result = alu_a - alu_b;
      2'b10: alu_result = alu_a & alu_b;
      2'b11: alu_result = alu_a | alu_b;
    endcase
    alu_zero = (alu_result == 16'h0000);
  end

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, OR_ = 2'b11;

  function automatic logic [15:0] ri(input logic [1:0] op, input logic [2:0] rd,
                                      input logic [2:0] s1, input logic [6:0] imm);
    return {op, rd, s1, 1'b1, imm};
  endfunction

  function automatic logic [15:0] rr(input logic [1:0] op, input logic [2:0] rd,
                                      input logic [2:0] s1, input logic [2:0] s2);
    return {op, rd, s1, 1'b0, s2, 4'b0000};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] ins);
    in_valid = v;
    in_instr = ins;
    @(posedge clk);
    #1;
  endtask

  // One isolated instruction: operands, writeback, then flag
  task automatic exec(input string tag, input logic [15:0] ins, input logic [15:0] ea,
                      input logic [15:0] eb, input logic [2:0] erd,
                      input logic [15:0] edata, input logic ez);
    drive(1'b1, ins);
    check({tag, ".a"}, alu_a, ea);
    check({tag, ".b"}, alu_b, eb);
    drive(1'b0, 16'h0000);
    check({tag, ".vld"}, {15'd0, res_valid}, 16'd1);
    check({tag, ".rd"}, {13'd0, res_rd}, {13'd0, erd});
    check({tag, ".data"}, res_data, edata);
    drive(1'b0, 16'h0000);
    check({tag, ".zf"}, {15'd0, zero_flag}, {15'd0, ez});
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_instr = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst.res_valid", {15'd0, res_valid}, 16'd0);
    check("rst.zero_flag", {15'd0, zero_flag}, 16'd0);
    check("rst.res_data",  res_data, 16'd0);
    check("rst.alu_a",     alu_a, 16'd0);
    rst_n = 1'b1;
    drive(1'b0, 16'h0000);
    check("rst.in_ready", {15'd0, in_ready}, 16'd1);

    // ADDI r1 = r0 + 5
    exec("addi", ri(ADD, 3'd1, 3'd0, 7'd5), 16'd0, 16'd5, 3'd1, 16'h0005, 1'b0);

    // Back-to-back dependency: r4 = 5, then r2 = r4 - r4
    drive(1'b1, ri(ADD, 3'd4, 3'd0, 7'd5));
    check("dep.ready0", {15'd0, in_ready}, 16'd1);
    drive(1'b1, rr(SUB, 3'd2, 3'd4, 3'd4));
`ifdef ALU_ISSUE_FWD_EN
    check("dep.ready", {15'd0, in_ready}, 16'd1);
    check("dep.a", alu_a, 16'd5);
    check("dep.b", alu_b, 16'd5);
    drive(1'b0, 16'h0000);
`else
    check("dep.ready", {15'd0, in_ready}, 16'd0);
    check("dep.stale_a", alu_a, 16'd0);
    drive(1'b0, 16'h0000);
    check("dep.ready1", {15'd0, in_ready}, 16'd1);
    check("dep.bubble", {15'd0, res_valid}, 16'd0);
    check("dep.a", alu_a, 16'd5);
    check("dep.b", alu_b, 16'd5);
    drive(1'b0, 16'h0000);
`endif
    check("dep.vld",  {15'd0, res_valid}, 16'd1);
    check("dep.rd",   {13'd0, res_rd}, 16'd2);
    check("dep.data", res_data, 16'd0);
    drive(1'b0, 16'h0000);
    check("dep.zf", {15'd0, zero_flag}, 16'd1);

    // Wrap: 0xFF81 + 0x7F = 0x0000
    exec("wrap1", ri(ADD, 3'd1, 3'd0, 7'h7F), 16'd0, 16'h007F, 3'd1, 16'h007F, 1'b0);
    exec("wrap2", ri(SUB, 3'd3, 3'd0, 7'h7F), 16'd0, 16'h007F, 3'd3, 16'hFF81, 1'b0);
    exec("wrap3", ri(ADD, 3'd3, 3'd3, 7'h7F), 16'hFF81, 16'h007F, 3'd3, 16'h0000, 1'b1);

    // Write to r0 is discarded but still retires
    exec("r0w", ri(OR_, 3'd0, 3'd0, 7'h7F), 16'd0, 16'h007F, 3'd0, 16'h007F, 1'b0);
    exec("r0r", rr(OR_, 3'd5, 3'd0, 3'd1), 16'd0, 16'h007F, 3'd5, 16'h007F, 1'b0);

    // Idle gap between two instructions
    drive(1'b1, ri(OR_, 3'd6, 3'd0, 7'd1));
    check("gap.op1", {14'd0, alu_op}, 16'd3);
    drive(1'b0, 16'h0000);
    check("gap.idle_a",  alu_a, 16'd0);
    check("gap.idle_b",  alu_b, 16'd0);
    check("gap.idle_op", {14'd0, alu_op}, 16'd0);
    check("gap.vld1",    {15'd0, res_valid}, 16'd1);
    drive(1'b1, ri(ADD, 3'd7, 3'd0, 7'd2));
    check("gap.vld2", {15'd0, res_valid}, 16'd0);
    drive(1'b0, 16'h0000);
    check("gap.vld3", {15'd0, res_valid}, 16'd1);
    check("gap.data", res_data, 16'd2);
    drive(1'b0, 16'h0000);

    // Set the zero flag, then reset with two instructions in flight
    exec("zset", ri(SUB, 3'd0, 3'd0, 7'd0), 16'd0, 16'd0, 3'd0, 16'd0, 1'b1);
    drive(1'b1, ri(ADD, 3'd1, 3'd0, 7'h33));
    drive(1'b1, ri(ADD, 3'd2, 3'd0, 7'h44));
    in_valid = 1'b0;
    check("mid.pre_vld", {15'd0, res_valid}, 16'd1);
    rst_n = 1'b0;
    #1;
    check("mid.res_valid", {15'd0, res_valid}, 16'd0);
    check("mid.res_rd",    {13'd0, res_rd}, 16'd0);
    check("mid.res_data",  res_data, 16'd0);
    check("mid.alu_a",     alu_a, 16'd0);
    check("mid.alu_b",     alu_b, 16'd0);
    check("mid.alu_op",    {14'd0, alu_op}, 16'd0);
    check("mid.zero_flag", {15'd0, zero_flag}, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 16'h0000);
    check("mid.in_ready", {15'd0, in_ready}, 16'd1);
    for (int r = 1; r < 8; r++) begin
      exec($sformatf("clr.r%0d", r), ri(OR_, 3'd0, r[2:0], 7'd0),
           16'd0, 16'd0, 3'd0, 16'd0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
